// File: rtl/irq_pkg.sv
// ============================================================================
// Module      : irq_pkg
// Description : Shared cause codes, mie bit positions and arbiter state type
//               for the hart-side interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

    // mcause exception codes for machine-level interrupts
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // mie / mip bit positions
    localparam int MIE_MSIE_BIT = 3;
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;

    // Bit positions inside the compact 3-bit pending vector {mei, mti, msi}
    localparam int PEND_MSI = 0;
    localparam int PEND_MTI = 1;
    localparam int PEND_MEI = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } arb_state_e;

endpackage : irq_pkg

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Fixed-priority encoder, pending vector -> {hit, cause code}.
//               Priority: MEI > MSI > MTI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [2:0] pend,
    output logic       hit,
    output logic [3:0] code
);

    always_comb begin
        hit  = |pend;
        code = 4'd0;
        if (pend[PEND_MEI]) begin
            code = IRQ_CODE_MEI;
        end else if (pend[PEND_MSI]) begin
            code = IRQ_CODE_MSI;
        end else if (pend[PEND_MTI]) begin
            code = IRQ_CODE_MTI;
        end
    end

endmodule : irq_prio_enc

`default_nettype wire

// File: rtl/irq_hart_arbiter.sv
// ============================================================================
// Module      : irq_hart_arbiter
// Description : Samples MTIP/MSIP/MEIP, masks with mie/mstatus.MIE and offers
//               one prioritised trap to the core until MRET. Optional accept
//               latency counter enabled by IRQ_ARB_LAT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_hart_arbiter
    import irq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LAT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mtip_i,
    input  logic             msip_i,
    input  logic             meip_i,
    input  logic [11:0]      mie_i,
    input  logic             mstatus_mie_i,
    output logic             irq_valid_o,
    input  logic             irq_ready_i,
    output logic [XLEN-1:0]  irq_cause_o,
    input  logic             mret_i,
    output logic [11:0]      mip_o,
    output logic             in_service_o,
    output logic [LAT_W-1:0] lat_cnt_o
);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic [2:0] r_mip;
    logic [3:0] r_code;
    logic [2:0] w_en;
    logic [2:0] w_pend;
    logic       w_hit;
    logic [3:0] w_code;
    logic [11:0] w_mip;
    logic       w_unused_mie;

    assign w_unused_mie = ^{mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    assign w_en[PEND_MSI] = mie_i[MIE_MSIE_BIT];
    assign w_en[PEND_MTI] = mie_i[MIE_MTIE_BIT];
    assign w_en[PEND_MEI] = mie_i[MIE_MEIE_BIT];

    // Pending uses the registered levels but the live enables, so a mask
    // change withdraws a request in the very next cycle.
    assign w_pend = r_mip & w_en & {3{mstatus_mie_i}};

    irq_prio_enc u_prio_enc (
        .pend (w_pend),
        .hit  (w_hit),
        .code (w_code)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mip   <= 3'b000;
            r_state <= IDLE;
            r_code  <= 4'd0;
        end else begin
            r_mip[PEND_MSI] <= msip_i;
            r_mip[PEND_MTI] <= mtip_i;
            r_mip[PEND_MEI] <= meip_i;
            r_state         <= w_state_next;
            if (r_state == IDLE && w_hit) begin
                r_code <= w_code;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (irq_ready_i) begin
                    w_state_next = SVC;
                end else if (!w_hit) begin
                    w_state_next = IDLE;
                end
            end
            SVC: begin
                if (mret_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_mip               = 12'd0;
        w_mip[MIE_MSIE_BIT] = r_mip[PEND_MSI];
        w_mip[MIE_MTIE_BIT] = r_mip[PEND_MTI];
        w_mip[MIE_MEIE_BIT] = r_mip[PEND_MEI];
    end

    assign mip_o        = w_mip;
    assign irq_valid_o  = (r_state == REQ);
    assign in_service_o = (r_state == SVC);
    assign irq_cause_o  = irq_valid_o ? {1'b1, {(XLEN-5){1'b0}}, r_code} : '0;

`ifdef IRQ_ARB_LAT_CNT_EN
    localparam logic [LAT_W-1:0] c_lat_one = 1;

    logic [LAT_W-1:0] r_lat_cnt;
    logic [LAT_W-1:0] r_lat_out;

    // Count covers stalled REQ cycles only; the accept cycle is excluded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lat_cnt <= '0;
            r_lat_out <= '0;
        end else begin
            if (r_state == IDLE && w_hit) begin
                r_lat_cnt <= '0;
            end else if (r_state == REQ && !irq_ready_i && r_lat_cnt != '1) begin
                r_lat_cnt <= r_lat_cnt + c_lat_one;
            end
            if (r_state == REQ && irq_ready_i) begin
                r_lat_out <= r_lat_cnt;
            end
        end
    end

    assign lat_cnt_o = r_lat_out;
`else
    assign lat_cnt_o = '0;
`endif

endmodule : irq_hart_arbiter

`default_nettype wire
